// File: rtl/pkt_rd.sv
// pkt_rd: drains one router output FIFO, strips header and parity, and
// streams the payload to a sink while checking parity, address and starvation.
// Ports: clk, rst (sync, active-low), vld_out/dout/rd_en (FIFO side),
// sink_ready/pl_data/pl_valid/pl_sop/pl_eop (sink side), pkt_len, pkt_done,
// parity_err, addr_err, abort, err_cnt.
// Optional feature macro: PKT_RD_ERRCNT_EN enables the saturating err_cnt
// register; without it err_cnt is tied to zero.
module pkt_rd #(
    parameter int unsigned PORT_ID   = 0,
    parameter int unsigned STALL_MAX = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_out,
    input  logic [7:0] dout,
    output logic       rd_en,
    input  logic       sink_ready,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_sop,
    output logic       pl_eop,
    output logic [5:0] pkt_len,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       addr_err,
    output logic       abort,
    output logic [7:0] err_cnt
);

    localparam int unsigned SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [1:0] PORT = 2'(PORT_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_PAR,
        S_CHK
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    len_q;
    logic [1:0]    addr_q;
    logic [7:0]    acc_q;
    logic [5:0]    issued_q;
    logic          inflight_q;
    logic [SW-1:0] stall_q;

    logic pay_room;
    logic pay_ret;
    logic stall_cyc;
    logic stall_hit;

    assign pay_room = (issued_q != len_q);
    // FIFO data returns one cycle after rd_en; in PAY every return is payload.
    assign pay_ret  = (state_q == S_PAY) && inflight_q;

    // A withheld sink grant is not starvation, so PAY only counts while
    // the sink is ready and a byte is still owed.
    assign stall_cyc = !vld_out && !inflight_q &&
                       (((state_q == S_PAY) && sink_ready && pay_room) ||
                        (state_q == S_PAR));
    assign stall_hit = stall_cyc && (stall_q == STALL_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (vld_out) state_d = S_HDR;
            S_HDR:  state_d = (dout[7:2] != 6'd0) ? S_PAY : S_PAR;
            S_PAY: begin
                if (stall_hit) begin
                    state_d = S_IDLE;
                end else if (!pay_room) begin
                    // issued_q reaches len_q in the cycle the last byte returns
                    state_d = S_PAR;
                end
            end
            S_PAR: begin
                if (stall_hit) begin
                    state_d = S_IDLE;
                end else if (vld_out) begin
                    state_d = S_CHK;
                end
            end
            S_CHK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_en      = 1'b0;
        pkt_done   = 1'b0;
        parity_err = 1'b0;
        addr_err   = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            S_IDLE: rd_en = vld_out;
            S_HDR:  rd_en = 1'b0;
            S_PAY: begin
                rd_en    = vld_out && sink_ready && pay_room;
                abort    = stall_hit;
                pkt_done = stall_hit;
                addr_err = stall_hit && (addr_q != PORT);
            end
            S_PAR: begin
                rd_en    = vld_out;
                abort    = stall_hit;
                pkt_done = stall_hit;
                addr_err = stall_hit && (addr_q != PORT);
            end
            S_CHK: begin
                pkt_done   = 1'b1;
                parity_err = (dout != acc_q);
                addr_err   = (addr_q != PORT);
            end
            default: rd_en = 1'b0;
        endcase
        // Never pull a byte out of the FIFO while reset is held.
        rd_en = rd_en && rst;
    end

    assign pl_valid = pay_ret;
    assign pl_data  = pay_ret ? dout : 8'd0;
    // With one read in flight, the returning byte's index equals issued_q.
    assign pl_sop   = pay_ret && (issued_q == 6'd1);
    assign pl_eop   = pay_ret && (issued_q == len_q);
    assign pkt_len  = len_q;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q      <= 6'd0;
            addr_q     <= 2'd0;
            acc_q      <= 8'd0;
            issued_q   <= 6'd0;
            inflight_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            inflight_q <= rd_en;
            if (state_q == S_HDR) begin
                len_q    <= dout[7:2];
                addr_q   <= dout[1:0];
                acc_q    <= dout;
                issued_q <= 6'd0;
            end
            if (state_q == S_PAY) begin
                if (rd_en) begin
                    issued_q <= issued_q + 6'd1;
                end
                if (pay_ret) begin
                    acc_q <= acc_q ^ dout;
                end
            end
            if (rd_en || !((state_q == S_PAY) || (state_q == S_PAR))) begin
                stall_q <= '0;
            end else if (stall_cyc) begin
                stall_q <= stall_q + SW'(1);
            end
        end
    end

`ifdef PKT_RD_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    assign err_evt = pkt_done && (parity_err || addr_err || abort);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/pkt_rd.md
PKT_RD -- requirements
Module: pkt_rd

Interface
REQ-001 SHALL have parameter PORT_ID, default 0, meaning the 2-bit router port this reader drains; the header address is checked against it.
REQ-002 SHALL have parameter STALL_MAX, default 63, meaning the mid-packet starvation limit in cycles.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 vld_out  input  1  router output FIFO non-empty.
REQ-006 dout  input  8  router FIFO read data, valid the cycle after rd_en.
REQ-007 rd_en  output  1  FIFO read request.
REQ-008 sink_ready  input  1  sink grants one payload byte; sampled at issue.
REQ-009 pl_data  output  8  payload byte.
REQ-010 pl_valid  output  1  pl_data valid this cycle.
REQ-011 pl_sop / pl_eop  output  1 each  first / last payload byte markers, qualified by pl_valid.
REQ-012 pkt_len  output  6  length field of the current header.
REQ-013 pkt_done  output  1  one-cycle pulse at packet end.
REQ-014 parity_err  output  1  one-cycle pulse with pkt_done on parity mismatch.
REQ-015 addr_err  output  1  one-cycle pulse with pkt_done if header addr != PORT_ID.
REQ-016 abort  output  1  one-cycle pulse with pkt_done on starvation abort.
REQ-017 err_cnt  output  8  error counter (see Configuration).

Function
REQ-018 SHALL implement FSM IDLE, HDR, PAY, PAR, CHK.
REQ-019 IDLE: vld_out=1 -> assert rd_en for exactly 1 cycle and go to HDR; rd_en SHALL assert in the first cycle vld_out=1 is seen, meeting the router's 30-cycle read deadline.
REQ-020 HDR: capture dout as the header; pkt_len=dout[7:2], addr=dout[1:0]; parity accumulator := dout; remaining := pkt_len; go to PAY if pkt_len>0, else PAR.
REQ-021 PAY: rd_en = vld_out & sink_ready & (issued<pkt_len); each issued byte SHALL appear on pl_data with pl_valid=1 exactly one cycle later; the sink SHALL accept it unconditionally.
REQ-022 pl_sop SHALL mark returned byte 1; pl_eop SHALL mark byte pkt_len; every returned byte SHALL be XORed into the accumulator.
REQ-023 After the last payload byte is issued, the next rd_en SHALL wait for that byte's return; PAR SHALL then issue one rd_en when vld_out=1, ignoring sink_ready.
REQ-024 CHK: compare the returned parity byte with the accumulator; pulse pkt_done plus any error flags; return to IDLE next cycle.
REQ-025 At most one read SHALL be in flight; back-to-back rd_en in PAY SHALL give one byte per cycle when vld_out=sink_ready=1.
REQ-026 Starvation counter: count consecutive PAY/PAR cycles with vld_out=0 and no read in flight; reset on any read; at STALL_MAX pulse abort+pkt_done, no parity_err, go to IDLE; payload already delivered SHALL not be retracted.
REQ-027 sink_ready=0 SHALL NOT advance the starvation counter.
REQ-028 The header and parity bytes SHALL never appear on pl_valid.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, rd_en=0, pl_valid=0, pl_sop=0, pl_eop=0, pl_data=0, pkt_len=0, all pulses=0, err_cnt=0, counters=0, including mid-packet; an in-flight read SHALL be discarded.

Configuration
REQ-030 Macro PKT_RD_ERRCNT_EN defined: err_cnt SHALL increment once per pkt_done with any of parity_err/addr_err/abort set, saturating at 255.
REQ-031 Macro undefined: err_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-032 Header 0x0C (len 3, addr 0), payload 0x11,0x22,0x33, parity 0x0C^0x11^0x22^0x33=0x0C, vld_out=sink_ready=1 -> rd_en 5 cycles, pl_valid 3 consecutive cycles, sop on 0x11, eop on 0x33, pkt_done=1, parity_err=0.
REQ-033 Same packet with parity byte 0x0D -> pkt_done=1, parity_err=1; with the macro defined, err_cnt 0->1.
REQ-034 Header 0x09 (len 2, addr 1) with PORT_ID=0 and correct parity -> addr_err=1, payload still delivered.
REQ-035 len 4 packet, sink_ready=0 for 10 cycles after byte 2 -> no rd_en for those cycles, no abort, bytes 3-4 delivered afterwards.
REQ-036 vld_out=0 after byte 1 of a len-5 packet -> abort+pkt_done STALL_MAX cycles later, FSM in IDLE; rst=0 mid-payload -> all outputs 0 the next cycle.
